edge_period_meter: RTL

Consumes the single-cycle rising/falling edge strobes produced by the asynchronous-input edge detector. Measures, in clk cycles, the period between consecutive accepted rising edges and the high time (rising to falling) of the synchronised signal. Rejects glitch edges and flags loss of signal by timeout. Feeds the receiver's frequency/lock logic.

---
 rtl/edge_period_meter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/edge_period_meter.sv
// edge_period_meter
//
// Measures the period between consecutive accepted rising edges and the high time
// (rising to falling) of a synchronised input. The input arrives as the one-cycle
// rising/falling strobes from the edge detector. Rising edges that come too soon after
// the last accepted one are rejected as glitches. A missing signal is flagged by timeout.
//
// Optional feature, macro PERIOD_AVG_EN: when defined, accepted periods are accumulated
// over 2**AVG_LOG2 samples. One valid then reports the truncated mean period together
// with the high time of the last sample. When undefined, every accepted period is
// reported.
//
// Parameters:
//   CNT_W       width of the period counter and of period/high_time
//   TIMEOUT     cycles without an accepted rising edge before timeout (2 .. 2**CNT_W-1)
//   MIN_PERIOD  rising edges closer than this to the last accepted edge are rejected
//   AVG_LOG2    log2 of the averaging depth (PERIOD_AVG_EN only)
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   en            measurement enable; low forces IDLE and discards any measurement
//   rising_edge   one-cycle rising strobe
//   falling_edge  one-cycle falling strobe
//   period        last measured period, in clk cycles
//   high_time     high time belonging to that period, in clk cycles
//   valid         one-cycle pulse: period and high_time updated
//   timeout       one-cycle pulse: signal lost, meter re-armed
//   glitch        one-cycle pulse: rising edge rejected

module edge_period_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 65535,
  parameter int unsigned MIN_PERIOD = 2,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rising_edge,
  input  logic             falling_edge,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             glitch
);

  // Elaboration-time parameter checks.
  if (TIMEOUT < 2 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
    $error("edge_period_meter: TIMEOUT out of range");
  end
  if (AVG_LOG2 > 16) begin : g_bad_avg
    $error("edge_period_meter: AVG_LOG2 too large");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;

  // cnt holds (cycles since the last accepted edge) - 1, so the terminal count is
  // TIMEOUT-1. The rejection threshold is compared against cnt+1, computed one bit
  // wider so a large MIN_PERIOD cannot alias.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   MIN_P   = (CNT_W + 1)'(MIN_PERIOD);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic             hi_seen_q, hi_seen_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             glitch_q, glitch_d;

  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             rise_ok;

  assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
  assign meas_period = cnt_inc[CNT_W-1:0];
  // Without a falling edge in this period the signal never went low, report 0.
  assign meas_high   = hi_seen_q ? hi_cap_q : '0;
  assign rise_ok     = rising_edge && (cnt_inc >= MIN_P);

`ifdef PERIOD_AVG_EN
  localparam int unsigned ACC_W   = CNT_W + AVG_LOG2;
  localparam int unsigned SAMP_W  = AVG_LOG2 + 1;
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'((2 ** AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [ACC_W-1:0]  acc_sum;

  assign acc_sum = acc_q + ACC_W'(meas_period);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    hi_cap_d  = hi_cap_q;
    hi_seen_d = hi_seen_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    glitch_d  = 1'b0;
`ifdef PERIOD_AVG_EN
    acc_d     = acc_q;
    samp_d    = samp_q;
`endif

    if (!en) begin
      // Disable wins over everything, including a strobe in the same cycle.
      state_d = IDLE;
`ifdef PERIOD_AVG_EN
      acc_d   = '0;
      samp_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
        end

        ARM: begin
          // The first edge only starts the count; there is nothing to report yet.
          if (rising_edge) begin
            cnt_d     = '0;
            hi_seen_d = 1'b0;
            state_d   = MEAS;
          end
        end

        MEAS: begin
          if (rise_ok) begin
            // An accepted edge beats a coincident timeout.
            cnt_d     = '0;
            hi_seen_d = 1'b0;
`ifdef PERIOD_AVG_EN
            if (samp_q == SAMP_LAST) begin
              period_d = acc_sum[AVG_LOG2 +: CNT_W];
              high_d   = meas_high;
              valid_d  = 1'b1;
              acc_d    = '0;
              samp_d   = '0;
            end else begin
              acc_d  = acc_sum;
              samp_d = samp_q + 1'b1;
            end
`else
            period_d = meas_period;
            high_d   = meas_high;
            valid_d  = 1'b1;
`endif
          end else if (cnt_q == TO_LAST) begin
            cnt_d     = '0;
            state_d   = ARM;
            timeout_d = 1'b1;
`ifdef PERIOD_AVG_EN
            acc_d     = '0;
            samp_d    = '0;
`endif
          end else begin
            cnt_d = meas_period;
            if (rising_edge) begin
              // Rejected rise; a falling strobe in the same cycle is dropped too.
              glitch_d = 1'b1;
            end else if (falling_edge) begin
              hi_cap_d  = meas_period;
              hi_seen_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      hi_cap_q  <= '0;
      hi_seen_q <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      glitch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      hi_cap_q  <= hi_cap_d;
      hi_seen_q <= hi_seen_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      glitch_q  <= glitch_d;
    end
  end

`ifdef PERIOD_AVG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      samp_q <= '0;
    end else begin
      acc_q  <= acc_d;
      samp_q <= samp_d;
    end
  end
`endif

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign glitch    = glitch_q;

endmodule
